// File: rtl/pulse_pkg.sv
// Shared pulse-parameter types, widths and env_word field helpers used by the
// processor-side pulse register and the pulse player.
package pulse_pkg;

  localparam int ENV_ADDR_WIDTH   = 12;
  localparam int ENV_LEN_WIDTH    = 12;
  localparam int ENV_WORD_WIDTH   = ENV_LEN_WIDTH + ENV_ADDR_WIDTH;
  localparam int PHASE_WIDTH      = 17;
  localparam int FREQ_WIDTH       = 9;
  localparam int AMP_WIDTH        = 16;
  localparam int CFG_WIDTH        = 4;
  localparam int PULSE_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ENV_WORD_WIDTH-1:0] env_word;
    logic [PHASE_WIDTH-1:0]    phase;
    logic [FREQ_WIDTH-1:0]     freq;
    logic [AMP_WIDTH-1:0]      amp;
    logic [CFG_WIDTH-1:0]      cfg;
  } pulse_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } player_state_t;

  // env_word is {length, start_addr}
  function automatic logic [ENV_LEN_WIDTH-1:0] env_len(input logic [ENV_WORD_WIDTH-1:0] word);
    return word[ENV_WORD_WIDTH-1:ENV_ADDR_WIDTH];
  endfunction

  function automatic logic [ENV_ADDR_WIDTH-1:0] env_addr(input logic [ENV_WORD_WIDTH-1:0] word);
    return word[ENV_ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pulse_player_if.sv
// Pulse parameter bus between the processor-side pulse register (master) and
// the pulse player (slave), including the playback outputs toward the DSP chain.
interface pulse_player_if #(
  parameter int FIFO_DEPTH = pulse_pkg::PULSE_FIFO_DEPTH
);

  logic                                cstrobe;
  logic [pulse_pkg::ENV_WORD_WIDTH-1:0] env_word;
  logic [pulse_pkg::PHASE_WIDTH-1:0]    phase;
  logic [pulse_pkg::FREQ_WIDTH-1:0]     freq;
  logic [pulse_pkg::AMP_WIDTH-1:0]      amp;
  logic [pulse_pkg::CFG_WIDTH-1:0]      cfg;
  logic                                ovf_clr;

  logic [pulse_pkg::PHASE_WIDTH-1:0]    phase_out;
  logic [pulse_pkg::FREQ_WIDTH-1:0]     freq_out;
  logic [pulse_pkg::AMP_WIDTH-1:0]      amp_out;
  logic [pulse_pkg::CFG_WIDTH-1:0]      cfg_out;
  logic [pulse_pkg::ENV_ADDR_WIDTH-1:0] env_addr;
  logic                                env_valid;
  logic                                pulse_start;
  logic                                busy;
  logic                                overflow;
  logic [$clog2(FIFO_DEPTH):0]         fifo_count;

  modport master (
    output cstrobe, env_word, phase, freq, amp, cfg, ovf_clr,
    input  phase_out, freq_out, amp_out, cfg_out, env_addr, env_valid,
           pulse_start, busy, overflow, fifo_count
  );

  modport slave (
    input  cstrobe, env_word, phase, freq, amp, cfg, ovf_clr,
    output phase_out, freq_out, amp_out, cfg_out, env_addr, env_valid,
           pulse_start, busy, overflow, fifo_count
  );

endinterface

// File: rtl/pulse_fifo.sv
// Synchronous first-word-visible FIFO of pulse_t; a push while full is accepted
// when a pop happens in the same cycle.
module pulse_fifo
  import pulse_pkg::*;
#(
  parameter int DEPTH = PULSE_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  pulse_t                din,
  output pulse_t                dout,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ZERO   = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(DEPTH);

  pulse_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == CNT_ZERO);
  assign full      = (count_r == CNT_FULL);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Entry storage; contents are only meaningful where the count says so.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pulse_player.sv
// Captures strobed pulses into a small queue and plays them one at a time:
// parameters held stable while the envelope address steps once per cycle.
module pulse_player
  import pulse_pkg::*;
#(
  parameter int FIFO_DEPTH = PULSE_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  pulse_player_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]          CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [ENV_LEN_WIDTH-1:0]  LEN_ZERO  = {ENV_LEN_WIDTH{1'b0}};
  localparam logic [ENV_LEN_WIDTH-1:0]  LEN_ONE   = ENV_LEN_WIDTH'(1);
  localparam logic [ENV_ADDR_WIDTH-1:0] ADDR_ZERO = {ENV_ADDR_WIDTH{1'b0}};
  localparam logic [ENV_ADDR_WIDTH-1:0] ADDR_ONE  = ENV_ADDR_WIDTH'(1);

  player_state_t              state_r;
  player_state_t              next_state_s;
  pulse_t                     strobe_s;
  pulse_t                     head_s;
  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [CNT_W-1:0]           fifo_count_s;
  logic                       pop_s;
  logic                       drop_s;
  logic [ENV_LEN_WIDTH-1:0]   head_len_s;
  logic [ENV_LEN_WIDTH-1:0]   remaining_r;
  logic [ENV_LEN_WIDTH-1:0]   next_remaining_s;
  logic [ENV_ADDR_WIDTH-1:0]  env_addr_r;
  logic [ENV_ADDR_WIDTH-1:0]  next_addr_s;
  logic                       env_valid_r;
  logic                       next_valid_s;
  logic                       pulse_start_r;
  logic                       next_start_s;
  logic                       overflow_r;
  logic [PHASE_WIDTH-1:0]     phase_r;
  logic [FREQ_WIDTH-1:0]      freq_r;
  logic [AMP_WIDTH-1:0]       amp_r;
  logic [CFG_WIDTH-1:0]       cfg_r;

  assign strobe_s = '{env_word: bus.env_word, phase: bus.phase, freq: bus.freq,
                      amp: bus.amp, cfg: bus.cfg};

  pulse_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cstrobe),
    .pop   (pop_s),
    .din   (strobe_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Popping on the last sample of a pulse chains the next one with no bubble.
  assign head_len_s = env_len(head_s.env_word);
  assign pop_s      = ~fifo_empty_s &
                      ((state_r == IDLE) | ((state_r == PLAY) & (remaining_r == LEN_ONE)));
  assign drop_s     = bus.cstrobe & fifo_full_s & ~pop_s;

  // Next state, envelope address, remaining length and playback flags.
  always_comb begin
    next_state_s     = state_r;
    next_remaining_s = remaining_r;
    next_addr_s      = env_addr_r;
    next_valid_s     = 1'b0;
    next_start_s     = 1'b0;
    if (pop_s) begin
      next_start_s     = 1'b1;
      next_addr_s      = env_addr(head_s.env_word);
      next_remaining_s = head_len_s;
      if (head_len_s != LEN_ZERO) begin
        next_valid_s = 1'b1;
        next_state_s = PLAY;
      end else begin
        next_valid_s = 1'b0;
        next_state_s = IDLE;
      end
    end else begin
      case (state_r)
        PLAY: begin
          if (remaining_r > LEN_ONE) begin
            next_addr_s      = env_addr_r + ADDR_ONE;
            next_remaining_s = remaining_r - LEN_ONE;
            next_valid_s     = 1'b1;
          end else begin
            next_remaining_s = LEN_ZERO;
            next_state_s     = IDLE;
          end
        end
        IDLE: begin
          next_state_s = IDLE;
        end
        default: begin
          next_state_s     = IDLE;
          next_remaining_s = LEN_ZERO;
        end
      endcase
    end
  end

  // FSM state, counters and playback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      remaining_r   <= LEN_ZERO;
      env_addr_r    <= ADDR_ZERO;
      env_valid_r   <= 1'b0;
      pulse_start_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      remaining_r   <= next_remaining_s;
      env_addr_r    <= next_addr_s;
      env_valid_r   <= next_valid_s;
      pulse_start_r <= next_start_s;
    end
  end

  // Pulse parameters latch on every pop, including zero-length pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= {PHASE_WIDTH{1'b0}};
      freq_r  <= {FREQ_WIDTH{1'b0}};
      amp_r   <= {AMP_WIDTH{1'b0}};
      cfg_r   <= {CFG_WIDTH{1'b0}};
    end else if (pop_s) begin
      phase_r <= head_s.phase;
      freq_r  <= head_s.freq;
      amp_r   <= head_s.amp;
      cfg_r   <= head_s.cfg;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  assign bus.phase_out   = phase_r;
  assign bus.freq_out    = freq_r;
  assign bus.amp_out     = amp_r;
  assign bus.cfg_out     = cfg_r;
  assign bus.env_addr    = env_addr_r;
  assign bus.env_valid   = env_valid_r;
  assign bus.pulse_start = pulse_start_r;
  assign bus.overflow    = overflow_r;
  assign bus.fifo_count  = fifo_count_s;
  assign bus.busy        = (state_r == PLAY) | (fifo_count_s != CNT_ZERO);

endmodule

// File: tb/tb_pulse_player.sv
// Directed bench for pulse_player: strobes push expected output samples into a
// scoreboard queue that a negedge monitor drains; timing points are checked inline.
module tb_pulse_player;

  typedef struct packed {
    logic        start;
    logic        valid;
    logic [11:0] addr;
    logic [16:0] ph;
    logic [8:0]  fr;
    logic [15:0] am;
    logic [3:0]  cf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t mon_got;
  exp_t mon_want;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_player_if #(.FIFO_DEPTH(4)) bus ();

  pulse_player #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, "_flags"}, {bus.env_valid, bus.pulse_start, bus.busy, bus.overflow, bus.fifo_count}, 64'd0);
    check({name, "_phfr"}, {bus.phase_out, bus.freq_out}, 64'd0);
    check({name, "_amcfad"}, {bus.amp_out, bus.cfg_out, bus.env_addr}, 64'd0);
  endtask

  task automatic expect_pulse(input logic [11:0] len, input logic [11:0] addr, input logic [16:0] ph,
                              input logic [8:0] fr, input logic [15:0] am, input logic [3:0] cf);
    logic [11:0] a;
    a = addr;
    if (len == 12'd0) begin
      exp_q.push_back('{start: 1'b1, valid: 1'b0, addr: addr, ph: ph, fr: fr, am: am, cf: cf});
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        exp_q.push_back('{start: (i == 0), valid: 1'b1, addr: a, ph: ph, fr: fr, am: am, cf: cf});
        a = a + 12'd1;
      end
    end
  endtask

  // Called at a negedge: strobe is sampled at the next posedge, returns at the following negedge.
  task automatic send(input logic [11:0] len, input logic [11:0] addr, input logic [16:0] ph,
                      input logic [8:0] fr, input logic [15:0] am, input logic [3:0] cf,
                      input bit queued, input bit clr);
    bus.cstrobe  = 1'b1;
    bus.env_word = {len, addr};
    bus.phase    = ph;
    bus.freq     = fr;
    bus.amp      = am;
    bus.cfg      = cf;
    bus.ovf_clr  = clr;
    if (queued) expect_pulse(len, addr, ph, fr, am, cf);
    @(negedge clk);
    bus.cstrobe  = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.env_word = ~{len, addr};
    bus.phase    = ~ph;
    bus.amp      = ~am;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int k;
    k = 0;
    while (bus.busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, bus.busy, 1'b0);
  endtask

  // Scoreboard monitor: every output event must match the next expected sample.
  always @(negedge clk) begin
    if (rst_n && (bus.env_valid || bus.pulse_start)) begin
      mon_got = '{start: bus.pulse_start, valid: bus.env_valid, addr: bus.env_addr,
                  ph: bus.phase_out, fr: bus.freq_out, am: bus.amp_out, cf: bus.cfg_out};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h, want no output", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          n_err++;
          $display("FAIL sb_event: got %h, want %h", mon_got, mon_want);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n        = 1'b0;
    bus.cstrobe  = 1'b0;
    bus.env_word = 24'd0;
    bus.phase    = 17'd0;
    bus.freq     = 9'd0;
    bus.amp      = 16'd0;
    bus.cfg      = 4'd0;
    bus.ovf_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single pulse: start two cycles after the strobe, exactly three valid samples.
    send(12'd3, 12'h010, 17'h00100, 9'h055, 16'h7FFF, 4'h3, 1'b1, 1'b0);
    check("t1_start_early", bus.pulse_start, 1'b0);
    check("t1_count", bus.fifo_count, 3'd1);
    check("t1_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("t1_start", bus.pulse_start, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", bus.env_valid, (i < 3));
      @(negedge clk);
    end
    check("t1_idle", bus.busy, 1'b0);

    // Back-to-back: second pulse follows with no bubble.
    send(12'd2, 12'h000, 17'h00200, 9'h011, 16'h1234, 4'h1, 1'b1, 1'b0);
    send(12'd2, 12'h100, 17'h00300, 9'h022, 16'h2345, 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", bus.env_valid, (i < 4));
      check("t2_start", bus.pulse_start, (i == 0) || (i == 2));
      @(negedge clk);
    end

    // Overflow, set-wins clear, zero length, address wrap, full-plus-pop.
    send(12'd100, 12'h200, 17'h00400, 9'h033, 16'h3456, 4'h4, 1'b1, 1'b0);
    base = cyc;
    @(negedge clk);
    send(12'd2, 12'hFFF, 17'h1FFFF, 9'h1FF, 16'hFFFF, 4'hF, 1'b1, 1'b0);
    send(12'd1, 12'h020, 17'h00500, 9'h044, 16'h4567, 4'h5, 1'b1, 1'b0);
    send(12'd0, 12'h030, 17'h1ABCD, 9'h066, 16'h5678, 4'h6, 1'b1, 1'b0);
    send(12'd3, 12'h040, 17'h00700, 9'h077, 16'h6789, 4'h7, 1'b1, 1'b0);
    send(12'd4, 12'h060, 17'h00800, 9'h088, 16'h789A, 4'h8, 1'b0, 1'b1);
    check("t3_full_count", bus.fifo_count, 3'd4);
    check("t3_ovf_set_wins", bus.overflow, 1'b1);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    check("t3_ovf_cleared", bus.overflow, 1'b0);
    check("t3_busy", bus.busy, 1'b1);
    while (cyc < base + 100) @(negedge clk);
    check("t3_count_before", bus.fifo_count, 3'd4);
    send(12'd1, 12'h050, 17'h00900, 9'h099, 16'h89AB, 4'h9, 1'b1, 1'b0);
    check("t3_fullpop_count", bus.fifo_count, 3'd4);
    check("t3_fullpop_ovf", bus.overflow, 1'b0);
    wait_idle(300, "t3_drain");
    check("t3_sb_empty", exp_q.size(), 0);

    // Reset mid-pulse with two entries queued.
    send(12'd50, 12'h080, 17'h00A00, 9'h0AA, 16'h9ABC, 4'hA, 1'b1, 1'b0);
    send(12'd5, 12'h090, 17'h00B00, 9'h0BB, 16'hABCD, 4'hB, 1'b1, 1'b0);
    send(12'd5, 12'h0A0, 17'h00C00, 9'h0CC, 16'hBCDE, 4'hC, 1'b1, 1'b0);
    @(negedge clk);
    check("t4_queued", bus.fifo_count, 3'd2);
    check("t4_playing", bus.env_valid, 1'b1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_no_replay_busy", bus.busy, 1'b0);
    check("t4_no_replay_count", bus.fifo_count, 3'd0);
    send(12'd1, 12'h0B0, 17'h00D00, 9'h0DD, 16'hCDEF, 4'hD, 1'b1, 1'b0);
    wait_idle(20, "t4_drain");
    check("final_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
